// File: rtl/stopwatch_bcd_core.sv
// Stopwatch time base: six-digit BCD MM:SS.cc counter with run/pause/lap/clear control.
// The display digits show the lap snapshot while in LAP, otherwise the live count.
module stopwatch_bcd_digit (
    input  logic [3:0] i_val,
    input  logic [3:0] i_max,
    input  logic       i_cin,
    output logic [3:0] o_nxt,
    output logic       o_cout
);
    always_comb begin
        o_nxt  = i_val;
        o_cout = 1'b0;
        if (i_cin) begin
            // >= rather than == so a digit can never stick outside its range
            if (i_val >= i_max) begin
                o_nxt  = 4'd0;
                o_cout = 1'b1;
            end else begin
                o_nxt = i_val + 4'd1;
            end
        end
    end
endmodule

module stopwatch_bcd_core #(
    parameter int SATURATE     = 0,
    parameter int MAX_MIN_TENS = 5
) (
    input  logic       clk,
    input  logic       hard_reset,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic [3:0] d,
    output logic [3:0] e,
    output logic [3:0] f,
    output logic [3:0] g,
    output logic [3:0] h,
    output logic [3:0] i,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // index 0 = centisecond units (d) ... index 5 = minute tens (i)
    localparam logic [5:0][3:0] DIG_MAX = {4'(MAX_MIN_TENS), 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0][3:0]  r_cnt;
    logic [5:0][3:0]  r_lap;
    logic [5:0][3:0]  w_inc;
    logic [5:0][3:0]  w_disp;
    logic [6:0]       w_carry;
    logic             r_overflow;
    logic             w_count;
    logic             w_term;
    logic             w_cap;
    logic             w_hold;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar k = 0; k < 6; k++) begin : g_dig
            stopwatch_bcd_digit u_dig (
                .i_val  (r_cnt[k]),
                .i_max  (DIG_MAX[k]),
                .i_cin  (w_carry[k]),
                .o_nxt  (w_inc[k]),
                .o_cout (w_carry[k+1])
            );
        end
    endgenerate

    // carry out of the top digit means every digit sits at its maximum
    assign w_term  = w_carry[6];
    assign w_count = tick && !btn_clr && (r_state == ST_RUN || r_state == ST_LAP);
    assign w_hold  = (SATURATE != 0) && w_term;

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        case (r_state)
            ST_IDLE:  if (btn_ss) w_state_nxt = ST_RUN;
            ST_RUN, ST_LAP: begin
                if (btn_ss) begin
                    w_state_nxt = ST_PAUSE;
                end else if (btn_lap) begin
                    w_state_nxt = ST_LAP;
                    w_cap       = 1'b1;
                end
            end
            ST_PAUSE: if (btn_ss) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_count && w_hold) w_state_nxt = ST_PAUSE;
        if (btn_clr) begin
            w_state_nxt = ST_IDLE;
            w_cap       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lap      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_count && w_term;
            if (btn_clr)                r_cnt <= '0;
            else if (w_count && !w_hold) r_cnt <= w_inc;
            if (btn_clr)    r_lap <= '0;
            else if (w_cap) r_lap <= r_cnt;
        end
    end

    assign w_disp     = (r_state == ST_LAP) ? r_lap : r_cnt;
    assign d          = w_disp[0];
    assign e          = w_disp[1];
    assign f          = w_disp[2];
    assign g          = w_disp[3];
    assign h          = w_disp[4];
    assign i          = w_disp[5];
    assign running    = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign lap_active = (r_state == ST_LAP);
    assign overflow   = r_overflow;
endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
Time-base and control core of the stopwatch. It produces the six BCD digits (d..i) that the display multiplexer consumes, in MM.SS.cc format. Digit mapping: i=minute tens, h=minute units, g=second tens, f=second units, e=centisecond tens, d=centisecond units; the multiplexer places the dots after h and f. The core takes a 100 Hz tick from the prescaler and single-cycle button pulses from the debouncers, and provides run/pause/lap(split)/clear control.

Parameters:
SATURATE, 0, 0: wrap 59:59.99 -> 00:00.00; 1: hold at 59:59.99 and pause
MAX_MIN_TENS, 5, maximum value of the minute-tens digit i (range 1..9)

Ports:
clk  in  1  system clock
hard_reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle pulse per centisecond
btn_ss  in  1  one-cycle start/stop pulse
btn_lap  in  1  one-cycle lap/split pulse
btn_clr  in  1  one-cycle clear pulse
d  out  4  BCD centisecond units
e  out  4  BCD centisecond tens
f  out  4  BCD second units
g  out  4  BCD second tens
h  out  4  BCD minute units
i  out  4  BCD minute tens
running  out  1  high in RUN or LAP
lap_active  out  1  high in LAP (display frozen)
overflow  out  1  one-cycle pulse on the terminal-count tick

Behaviour:
- Reset (hard_reset low, asynchronous): state IDLE; cnt = 0; lap_reg = 0; d..i = 0; running = 0; lap_active = 0; overflow = 0. Releasing reset mid-count restarts from IDLE with zeros.
- Registers:
  - cnt: six BCD digits. Digit ranges are d 0-9, e 0-9, f 0-9, g 0-5, h 0-9, i 0-MAX_MIN_TENS.
  - lap_reg: six BCD digits.
  - state: 2 bits.
- Ripple-carry increment: d wraps 9->0 and carries into e; e 9->0 carries into f; f 9->0 carries into g; g 5->0 carries into h; h 9->0 carries into i. Any digit never holds a value outside its range.
- Terminal count is i=MAX_MIN_TENS, h=9, g=5, f=9, e=9, d=9. A tick at terminal count does the following:
  - SATURATE=0: cnt becomes all zeros and the state is unchanged.
  - SATURATE=1: cnt holds and the state goes to PAUSE; from LAP it also goes to PAUSE.
  - In both cases overflow pulses high in the following cycle.
- Counting rule: a tick is counted in cycle n if and only if the state at cycle n is RUN or LAP and btn_clr=0. The new cnt is visible the cycle after the edge that sampled tick.
- Event priority in the same cycle: btn_clr > btn_ss > btn_lap. A lower-priority pulse in the same cycle is discarded.
- States and transitions:
  - IDLE:
    - btn_ss -> RUN.
    - btn_lap is ignored.
  - RUN:
    - btn_ss -> PAUSE.
    - btn_lap -> LAP, with lap_reg <= cnt (the pre-increment value if tick is in the same cycle).
  - LAP: counting continues.
    - btn_lap -> LAP, recapturing lap_reg <= cnt (split).
    - btn_ss -> PAUSE.
  - PAUSE:
    - btn_ss -> RUN.
    - btn_lap is ignored.
  - Any state: btn_clr -> IDLE, with cnt = 0 and lap_reg = 0. A tick in the same cycle is dropped.
- Outputs:
  - d..i = lap_reg when the state is LAP, otherwise cnt. This is a combinational mux of registered values, with no extra latency.
  - running and lap_active are decoded from the registered state.
- Unused state encoding -> IDLE on the next clock.
- A tick in the same cycle as a RUN->PAUSE btn_ss is counted. A tick in the same cycle as a PAUSE->RUN or IDLE->RUN btn_ss is not counted.

Test Plan:
1. Reset, then btn_ss, then 100 ticks -> d..i read 00:01.00 (i=0 h=0 g=0 f=1 e=0 d=0); running=1.
2. Preload to 00:59.99 via 5999 ticks, then one tick -> 01:00.00; then btn_ss with tick in the same cycle -> tick counted, state PAUSE; further ticks leave cnt unchanged.
3. Running at 00:12.34, btn_lap -> display frozen at 00:12.34 with lap_active=1 while 50 more ticks arrive; btn_lap again -> display 00:12.84; btn_ss -> PAUSE, display shows live cnt 00:12.84.
4. Drive btn_clr, btn_ss and tick in the same cycle while in RUN -> next cycle state IDLE, all digits 0, running=0.
5. SATURATE=0, cnt at 59:59.99, one tick -> 00:00.00, overflow high for exactly one cycle, still RUN. SATURATE=1 -> holds 59:59.99, overflow pulse, state PAUSE.
6. Assert hard_reset asynchronously mid-RUN between clock edges -> outputs 0 immediately; after release, ticks are ignored until btn_ss.
